// File: rtl/ifu_fetch_ctrl.sv
// Fetch-control stage: owns the fetch PC, keeps one imem request in flight and feeds decode through a one-entry slot.
// Optional IFU_PERF_CNT_EN adds slot-write and discarded-response counters.
module ifu_fetch_ctrl #(
   parameter int              PC_W     = 64,
   parameter int              INST_W   = 32,
   parameter logic [PC_W-1:0] START_PC = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [PC_W-1:0]   imem_req_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic [INST_W-1:0] bpu_inst,
   output logic [PC_W-1:0]   bpu_pc,
   input  logic [PC_W-1:0]   bpu_pc_nxt,
   input  logic              bpu_jump,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [INST_W-1:0] id_inst,
   output logic [PC_W-1:0]   id_pc,
   output logic              id_pred_taken
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [63:0]       perf_fetch_cnt,
   output logic [31:0]       perf_kill_cnt
`endif
);

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_KILL  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [PC_W-1:0]     r_pc;
   logic                r_id_valid;
   logic [INST_W-1:0]   r_id_inst;
   logic [PC_W-1:0]     r_id_pc;
   logic                r_id_taken;

   logic                w_can_issue;
   logic                w_req_fire;
   logic                w_redirect;
   logic                w_slot_wr;
   logic                w_discard;

   assign w_can_issue    = !r_id_valid || id_ready;
   assign imem_req_valid = (r_state == S_REQ) && w_can_issue;
   assign imem_req_addr  = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;
   // Redirects are ignored in RESET: the first fetch always targets START_PC.
   assign w_redirect     = redirect_valid && (r_state != S_RESET);
   assign w_slot_wr      = (r_state == S_WAIT) && imem_rsp_valid && !w_redirect;
   assign w_discard      = imem_rsp_valid &&
                           ((r_state == S_KILL) || ((r_state == S_WAIT) && w_redirect));

   assign bpu_inst       = imem_rsp_data;
   assign bpu_pc         = r_pc;
   assign id_valid       = r_id_valid;
   assign id_inst        = r_id_inst;
   assign id_pc          = r_id_pc;
   assign id_pred_taken  = r_id_taken;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_RESET: w_state_next = S_REQ;
         S_REQ: begin
            if (w_req_fire) begin
               w_state_next = w_redirect ? S_KILL : S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               w_state_next = S_REQ;
            end else if (w_redirect) begin
               w_state_next = S_KILL;
            end
         end
         S_KILL: begin
            if (imem_rsp_valid) begin
               w_state_next = S_REQ;
            end
         end
         default: w_state_next = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_RESET;
         r_pc       <= START_PC;
         r_id_valid <= 1'b0;
         r_id_inst  <= '0;
         r_id_pc    <= '0;
         r_id_taken <= 1'b0;
      end else begin
         r_state <= w_state_next;

         if (w_redirect) begin
            r_pc <= redirect_pc;
         end else if (w_slot_wr) begin
            r_pc <= bpu_pc_nxt;
         end

         // A refill in the same cycle as a drain keeps the slot occupied.
         if (w_redirect) begin
            r_id_valid <= 1'b0;
         end else if (w_slot_wr) begin
            r_id_valid <= 1'b1;
         end else if (r_id_valid && id_ready) begin
            r_id_valid <= 1'b0;
         end

         if (w_slot_wr) begin
            r_id_inst  <= imem_rsp_data;
            r_id_pc    <= r_pc;
            r_id_taken <= bpu_jump;
         end
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [63:0] r_fetch_cnt;
   logic [31:0] r_kill_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_cnt <= '0;
         r_kill_cnt  <= '0;
      end else begin
         if (w_slot_wr) begin
            r_fetch_cnt <= r_fetch_cnt + 64'd1;
         end
         if (w_discard) begin
            r_kill_cnt <= r_kill_cnt + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = r_fetch_cnt;
   assign perf_kill_cnt  = r_kill_cnt;
`else
   logic w_discard_unused;
   assign w_discard_unused = w_discard;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomised scoreboard bench for ifu_fetch_ctrl: an imem model, a JAL-aware predictor and a
// reference of which responses survive redirects/resets feed an expected-slot queue.
module tb_ifu_fetch_ctrl;

   localparam int          PC_W     = 64;
   localparam int          INST_W   = 32;
   localparam logic [63:0] START_PC = 64'h0000_0000_8000_0000;
   localparam int          N_CYC    = 4000;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              imem_req_valid;
   logic              imem_req_ready = 1'b0;
   logic [PC_W-1:0]   imem_req_addr;
   logic              imem_rsp_valid = 1'b0;
   logic [INST_W-1:0] imem_rsp_data = '0;
   logic [INST_W-1:0] bpu_inst;
   logic [PC_W-1:0]   bpu_pc;
   logic [PC_W-1:0]   bpu_pc_nxt;
   logic              bpu_jump;
   logic              redirect_valid = 1'b0;
   logic [PC_W-1:0]   redirect_pc = '0;
   logic              id_valid;
   logic              id_ready = 1'b0;
   logic [INST_W-1:0] id_inst;
   logic [PC_W-1:0]   id_pc;
   logic              id_pred_taken;
`ifdef IFU_PERF_CNT_EN
   logic [63:0]       perf_fetch_cnt;
   logic [31:0]       perf_kill_cnt;
`endif

   always #5 clk = ~clk;

   ifu_fetch_ctrl #(.PC_W(PC_W), .INST_W(INST_W), .START_PC(START_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .bpu_inst       (bpu_inst),
      .bpu_pc         (bpu_pc),
      .bpu_pc_nxt     (bpu_pc_nxt),
      .bpu_jump       (bpu_jump),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pred_taken  (id_pred_taken)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_kill_cnt  (perf_kill_cnt)
`endif
   );

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        taken;
   } slot_t;

   slot_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    n_pop    = 0;

   // Instruction memory contents: START_PC holds a JAL +8, elsewhere a hash with occasional JALs.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] w;
      if (a == START_PC) return 32'h0080_006F;
      w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
      if (w[3:0] == 4'h0) w[6:0] = 7'h6F;
      else if (w[6:0] == 7'h6F) w[0] = 1'b0;
      return w;
   endfunction

   function automatic logic is_jal(input logic [31:0] inst);
      return inst[6:0] == 7'h6F;
   endfunction

   function automatic logic [63:0] pred_next(input logic [63:0] pc, input logic [31:0] inst);
      logic [63:0] imm;
      imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      return is_jal(inst) ? pc + imm : pc + 64'd4;
   endfunction

   // Static predictor stand-in, combinational as the real one is.
   always_comb begin
      bpu_jump   = is_jal(bpu_inst);
      bpu_pc_nxt = pred_next(bpu_pc, bpu_inst);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expected entry on every decode transfer; also checks held slots stay put.
   initial begin
      slot_t       e;
      logic        hold_prev = 1'b0;
      logic [63:0] prev_pc = '0;
      logic [31:0] prev_inst = '0;
      forever begin
         @(negedge clk);
         if (rst && hold_prev) begin
            check("held_valid", {63'd0, id_valid}, 64'd1);
            check("held_pc", id_pc, prev_pc);
            check("held_inst", {32'd0, id_inst}, {32'd0, prev_inst});
         end
         hold_prev = rst && id_valid && !id_ready && !redirect_valid;
         prev_pc   = id_pc;
         prev_inst = id_inst;
         if (rst && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_slot: got pc %h inst %h, required none", id_pc, id_inst);
            end else begin
               e = exp_q.pop_front();
               n_pop++;
               check("id_pc", id_pc, e.pc);
               check("id_inst", {32'd0, id_inst}, {32'd0, e.inst});
               check("id_pred_taken", {63'd0, id_pred_taken}, {63'd0, e.taken});
               $display("xfer pc=%h inst=%h taken=%0d", id_pc, id_inst, id_pred_taken);
            end
         end
      end
   end

   // Stimulus + imem model + reference of surviving responses.
   initial begin
      logic        outstanding = 1'b0;
      logic        out_live = 1'b0;
      logic [63:0] out_addr = '0;
      logic [63:0] exp_addr = START_PC;
      logic        chk_rst = 1'b1;
      int          cnt = 0;
      int          lat = 1;
      int          since_rst = 0;
      int          rst_cnt = 0;
      int          live_cnt = 0;
      int          dead_cnt = 0;
      slot_t       s;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      check("rst_id_valid", {63'd0, id_valid}, 64'd0);
      check("rst_id_pc", id_pc, 64'd0);

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(posedge clk);
         #1;
         // Occasional one-cycle reset while a fetch is in flight.
         rst = !(rst_cnt < 2 && cyc > 1500 * (rst_cnt + 1) && outstanding);
         if (!rst) begin
            imem_req_ready = 1'b0;
            id_ready       = 1'b0;
            redirect_valid = 1'b0;
            imem_rsp_valid = 1'b0;
         end else begin
            imem_rsp_valid = outstanding && (cnt == 0);
            imem_rsp_data  = imem_rsp_valid ? mem_word(out_addr) : $urandom;
            if (cyc < 60) begin
               imem_req_ready = 1'b1;
               id_ready       = !(cyc >= 30 && cyc < 40);
               redirect_valid = 1'b0;
               lat            = 1;
            end else begin
               imem_req_ready = ($urandom_range(0, 3) != 0);
               id_ready       = ($urandom_range(0, 3) != 0);
               redirect_valid = (since_rst >= 2) && ($urandom_range(0, 11) == 0);
               lat            = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 7) == 0)
               redirect_pc = {$urandom, $urandom} & ~64'd3;
            else
               redirect_pc = START_PC + 64'h100 + 64'($urandom_range(0, 255) * 4);
         end

         @(negedge clk);
         #1;
         if (!rst) begin
            outstanding = 1'b0;
            exp_q.delete();
            exp_addr  = START_PC;
            since_rst = 0;
            live_cnt  = 0;
            dead_cnt  = 0;
            chk_rst   = 1'b1;
            rst_cnt++;
            $display("reset applied at cycle %0d", cyc);
            continue;
         end
         since_rst++;
         if (chk_rst) begin
            chk_rst = 1'b0;
            check("post_rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
            check("post_rst_id_valid", {63'd0, id_valid}, 64'd0);
            check("post_rst_id_inst", {32'd0, id_inst}, 64'd0);
            check("post_rst_id_pc", id_pc, 64'd0);
            check("post_rst_id_taken", {63'd0, id_pred_taken}, 64'd0);
         end
         if (imem_req_valid) begin
            check("single_outstanding", {63'd0, outstanding}, 64'd0);
            check("issue_needs_space", {63'd0, id_valid && !id_ready}, 64'd0);
         end
         if (imem_rsp_valid) begin
            outstanding = 1'b0;
            if (out_live && !redirect_valid) begin
               s.pc    = out_addr;
               s.inst  = mem_word(out_addr);
               s.taken = is_jal(s.inst);
               exp_q.push_back(s);
               exp_addr = pred_next(out_addr, s.inst);
               live_cnt++;
            end else begin
               dead_cnt++;
               $display("rsp discarded addr=%h", out_addr);
            end
         end else if (outstanding) begin
            cnt--;
         end
         if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_addr);
            $display("req addr=%h", imem_req_addr);
            outstanding = 1'b1;
            out_live    = 1'b1;
            out_addr    = exp_addr;
            cnt         = lat - 1;
         end
         if (redirect_valid) begin
            out_live = 1'b0;
            exp_q.delete();
            exp_addr = redirect_pc;
            $display("redirect to %h", redirect_pc);
         end
      end

      @(negedge clk);
      n_checks++;
      if (n_pop <= 100) begin
         n_fail++;
         $display("FAIL transfers: got %0d, required more than 100", n_pop);
      end
`ifdef IFU_PERF_CNT_EN
      check("perf_fetch_cnt", perf_fetch_cnt, 64'(live_cnt));
      check("perf_kill_cnt", {32'd0, perf_kill_cnt}, 64'(dead_cnt));
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
